// File: rtl/pcileech_pkg.sv
// Shared definitions for the FT601 TX framer: frame geometry, port IDs and tag dword layout.
// A frame is one tag dword followed by seven 32-bit data slots.
package pcileech_pkg;

   localparam int FRAME_SLOTS  = 7;
   localparam int SLOT_W       = 32;
   localparam int TAG_W        = 4;
   localparam int FILL_W       = 3;
   localparam int TAG_CNT_LSB  = 29;
   localparam int TAG_RSVD_BIT = 28;

   typedef enum logic [1:0] {
      PORT_TLP  = 2'd0,
      PORT_CFG  = 2'd1,
      PORT_LOOP = 2'd2,
      PORT_CMD  = 2'd3
   } port_id_e;

   function automatic logic [TAG_W-1:0] slot_tag(input port_id_e port, input logic [1:0] ctx);
      return {port, ctx};
   endfunction

endpackage

// File: rtl/pcileech_prio_arb4.sv
// Four-way fixed-priority arbiter: one-hot grant, request 0 wins, nothing granted when en=0.
module pcileech_prio_arb4 (
   input  logic       en,
   input  logic [3:0] req,
   output logic [3:0] grant
);

   always_comb begin
      grant = 4'b0000;
      if (en) begin
         if (req[0])      grant = 4'b0001;
         else if (req[1]) grant = 4'b0010;
         else if (req[2]) grant = 4'b0100;
         else if (req[3]) grant = 4'b1000;
      end
   end

endmodule

// File: rtl/pcileech_tx_framer.sv
// Drains four source FIFOs in strict priority and packs their words into 256-bit tagged frames.
// Frames are handed to a single output register when full or after an idle flush timeout.
import pcileech_pkg::*;

module pcileech_tx_framer #(
   parameter int PARAM_FLUSH_CYCLES = 16
) (
   input  logic         clk,
   input  logic         rst,
   output logic [255:0] dout,
   output logic         valid,
   input  logic         rd_en,
   input  logic [31:0]  p0_din,
   input  logic [1:0]   p0_ctx,
   input  logic         p0_wr_en,
   input  logic         p0_has_data,
   output logic         p0_req_data,
   input  logic [31:0]  p1_din,
   input  logic [1:0]   p1_ctx,
   input  logic         p1_wr_en,
   input  logic         p1_has_data,
   output logic         p1_req_data,
   input  logic [31:0]  p2_din,
   input  logic [1:0]   p2_ctx,
   input  logic         p2_wr_en,
   input  logic         p2_has_data,
   output logic         p2_req_data,
   input  logic [31:0]  p3_din,
   input  logic [1:0]   p3_ctx,
   input  logic         p3_wr_en,
   input  logic         p3_has_data,
   output logic         p3_req_data
);

   localparam logic [7:0] FLUSH_VAL = 8'(PARAM_FLUSH_CYCLES);

   logic [3:0]        has_data;
   logic [3:0]        wr_en;
   logic [3:0]        grant;
   logic [SLOT_W-1:0] din_arr [4];
   logic [1:0]        ctx_arr [4];

   logic [FILL_W-1:0] fill_reg;
   logic              pending_reg;
   logic [7:0]        idle_reg;
   logic [255:0]      dout_reg;
   logic              valid_reg;

   logic              land_any;
   logic [SLOT_W-1:0] land_data;
   logic [TAG_W-1:0]  land_tag;
   logic [FILL_W:0]   fill_after;
   logic              full_case;
   logic              flush_case;
   logic              grant_en;
   logic              grant_any;
   logic              out_free;
   logic              handoff;

   logic [SLOT_W*FRAME_SLOTS-1:0] frame_words;
   logic [TAG_W*FRAME_SLOTS-1:0]  frame_tags;
   logic [255:0]                  frame_next;

   assign has_data   = {p3_has_data, p2_has_data, p1_has_data, p0_has_data};
   assign wr_en      = {p3_wr_en, p2_wr_en, p1_wr_en, p0_wr_en};
   assign din_arr[0] = p0_din;
   assign din_arr[1] = p1_din;
   assign din_arr[2] = p2_din;
   assign din_arr[3] = p3_din;
   assign ctx_arr[0] = p0_ctx;
   assign ctx_arr[1] = p1_ctx;
   assign ctx_arr[2] = p2_ctx;
   assign ctx_arr[3] = p3_ctx;

   // The grant protocol keeps wr_en one-hot, so a plain scan selects the landing word.
   always_comb begin
      land_any  = 1'b0;
      land_data = '0;
      land_tag  = '0;
      for (int i = 0; i < 4; i++) begin
         if (wr_en[i]) begin
            land_any  = 1'b1;
            land_data = din_arr[i];
            land_tag  = slot_tag(port_id_e'(i), ctx_arr[i]);
         end
      end
   end

   assign fill_after = {1'b0, fill_reg} + {{FILL_W{1'b0}}, land_any};
   assign full_case  = (fill_after == (FILL_W+1)'(FRAME_SLOTS));
   assign grant_en   = !rst &&
                       (({1'b0, fill_reg} + {{FILL_W{1'b0}}, pending_reg}) < (FILL_W+1)'(FRAME_SLOTS));
   assign grant_any  = |grant;
   assign out_free   = !valid_reg || rd_en;
   assign flush_case = (fill_reg != '0) && !pending_reg && !grant_any && (idle_reg == FLUSH_VAL);
   assign handoff    = out_free && (full_case || flush_case);

   pcileech_prio_arb4 u_arb (
      .en    (grant_en),
      .req   (has_data),
      .grant (grant)
   );

   assign p0_req_data = grant[0];
   assign p1_req_data = grant[1];
   assign p2_req_data = grant[2];
   assign p3_req_data = grant[3];

   for (genvar gi = 0; gi < FRAME_SLOTS; gi++) begin : g_slot
      logic [SLOT_W-1:0] data_reg;
      logic [TAG_W-1:0]  tag_reg;
      logic              land_here;

      assign land_here = land_any && (fill_reg == FILL_W'(gi));
      // A word completing the frame is merged straight into the outgoing frame.
      assign frame_words[SLOT_W*gi +: SLOT_W] = (full_case && land_here) ? land_data : data_reg;
      assign frame_tags[TAG_W*gi +: TAG_W]    = (full_case && land_here) ? land_tag : tag_reg;

      always_ff @(posedge clk) begin
         if (rst) begin
            data_reg <= '0;
            tag_reg  <= '0;
         end else if (handoff) begin
            if (gi == 0 && land_any && !full_case) begin
               data_reg <= land_data;
               tag_reg  <= land_tag;
            end else begin
               data_reg <= '0;
               tag_reg  <= '0;
            end
         end else if (land_here) begin
            data_reg <= land_data;
            tag_reg  <= land_tag;
         end
      end
   end

   always_comb begin
      frame_next = '0;
      frame_next[TAG_CNT_LSB +: FILL_W] = full_case ? FILL_W'(FRAME_SLOTS) : fill_reg;
      frame_next[TAG_RSVD_BIT]          = 1'b0;
      frame_next[TAG_W*FRAME_SLOTS-1:0] = frame_tags;
      frame_next[255:SLOT_W]            = frame_words;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fill_reg    <= '0;
         pending_reg <= 1'b0;
         idle_reg    <= '0;
         dout_reg    <= '0;
         valid_reg   <= 1'b0;
      end else begin
         pending_reg <= grant_any;

         if (handoff)
            fill_reg <= (land_any && !full_case) ? FILL_W'(1) : '0;
         else
            fill_reg <= fill_after[FILL_W-1:0];

         if (grant_any || land_any || handoff)
            idle_reg <= '0;
         else if (fill_reg != '0 && idle_reg < FLUSH_VAL)
            idle_reg <= idle_reg + 8'd1;

         if (handoff) begin
            dout_reg  <= frame_next;
            valid_reg <= 1'b1;
         end else if (rd_en) begin
            valid_reg <= 1'b0;
         end
      end
   end

   assign dout  = dout_reg;
   assign valid = valid_reg;

endmodule

// File: tb/tb_pcileech_tx_framer.sv
// Directed bench for pcileech_tx_framer: four modelled source FIFOs with 1-cycle read latency
// feed the framer; each scenario task checks the frames it produces against hand-computed values.
module tb_pcileech_tx_framer;

   logic         clk = 1'b0;
   logic         rst;
   logic         rd_en;
   logic [255:0] dout;
   logic         valid;
   logic [31:0]  din [4];
   logic [1:0]   ctx [4];
   logic [3:0]   wr_en;
   logic [3:0]   has_data;
   logic [3:0]   req;

   logic [31:0]  fmem [4][64];
   logic [1:0]   fctx [4][64];
   int           wptr [4];
   int           rptr [4];

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   pcileech_tx_framer #(.PARAM_FLUSH_CYCLES(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .dout        (dout),
      .valid       (valid),
      .rd_en       (rd_en),
      .p0_din      (din[0]),
      .p0_ctx      (ctx[0]),
      .p0_wr_en    (wr_en[0]),
      .p0_has_data (has_data[0]),
      .p0_req_data (req[0]),
      .p1_din      (din[1]),
      .p1_ctx      (ctx[1]),
      .p1_wr_en    (wr_en[1]),
      .p1_has_data (has_data[1]),
      .p1_req_data (req[1]),
      .p2_din      (din[2]),
      .p2_ctx      (ctx[2]),
      .p2_wr_en    (wr_en[2]),
      .p2_has_data (has_data[2]),
      .p2_req_data (req[2]),
      .p3_din      (din[3]),
      .p3_ctx      (ctx[3]),
      .p3_wr_en    (wr_en[3]),
      .p3_has_data (has_data[3]),
      .p3_req_data (req[3])
   );

   // Source FIFO model: a read strobe presents the word one cycle later; reset empties it.
   always_comb begin
      has_data = 4'b0000;
      for (int n = 0; n < 4; n++) has_data[n] = (wptr[n] != rptr[n]);
   end

   always @(posedge clk) begin
      for (int n = 0; n < 4; n++) begin
         if (rst) begin
            rptr[n]  <= wptr[n];
            wr_en[n] <= 1'b0;
         end else if (req[n] && has_data[n]) begin
            din[n]   <= fmem[n][rptr[n] % 64];
            ctx[n]   <= fctx[n][rptr[n] % 64];
            wr_en[n] <= 1'b1;
            rptr[n]  <= rptr[n] + 1;
         end else begin
            wr_en[n] <= 1'b0;
         end
      end
   end

   task automatic push(input int n, input logic [31:0] data, input logic [1:0] c);
      fmem[n][wptr[n] % 64] = data;
      fctx[n][wptr[n] % 64] = c;
      wptr[n] = wptr[n] + 1;
   endtask

   task automatic wait_valid(input int max_cyc, output int cyc, output bit ok);
      ok  = 1'b0;
      cyc = 0;
      for (int i = 1; i <= max_cyc; i++) begin
         @(negedge clk);
         if (valid === 1'b1) begin
            cyc = i;
            ok  = 1'b1;
            $display("frame: tag=%08h slot0=%08h after %0d cycles", dout[31:0], dout[63:32], i);
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      rd_en = 1'b0;
      repeat (2) @(negedge clk);
      push(0, 32'h1111_1111, 2'b00);
      #1;
      checks++;
      if (req !== 4'b0000) $display("FAIL reset_req: got %b expected 0000", req);
      else passed++;
      checks++;
      if (valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid);
      else passed++;
      checks++;
      if (dout !== 256'd0) $display("FAIL reset_dout: got %h expected 0", dout);
      else passed++;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (valid !== 1'b0) $display("FAIL reset_flushed_word: got valid %b expected 0", valid);
      else passed++;
   endtask

   task automatic test_single_flush();
      int cyc;
      bit ok;
      rd_en = 1'b1;
      push(0, 32'hDEAD_BEEF, 2'b01);
      wait_valid(40, cyc, ok);
      checks++;
      if (!ok || cyc != 19) $display("FAIL flush_latency: got %0d (ok=%0b) expected 19", cyc, ok);
      else passed++;
      checks++;
      if (dout[31:0] !== 32'h2000_0001) $display("FAIL flush_tag: got %h expected 20000001", dout[31:0]);
      else passed++;
      checks++;
      if (dout[63:32] !== 32'hDEAD_BEEF) $display("FAIL flush_data: got %h expected deadbeef", dout[63:32]);
      else passed++;
      checks++;
      if (dout[255:64] !== 192'd0) $display("FAIL flush_unused: got %h expected 0", dout[255:64]);
      else passed++;
      @(negedge clk);
      checks++;
      if (valid !== 1'b0) $display("FAIL flush_pop: got valid %b expected 0", valid);
      else passed++;
   endtask

   task automatic test_back_to_back();
      int cyc;
      bit ok;
      logic [31:0] got;
      rd_en = 1'b1;
      for (int i = 0; i < 7; i++) push(2, 32'(i), 2'b00);
      wait_valid(30, cyc, ok);
      checks++;
      if (!ok || cyc != 8) $display("FAIL b2b_latency: got %0d (ok=%0b) expected 8", cyc, ok);
      else passed++;
      checks++;
      if (dout[31:0] !== 32'hE888_8888) $display("FAIL b2b_tag: got %h expected e8888888", dout[31:0]);
      else passed++;
      for (int i = 0; i < 7; i++) begin
         got = dout[32*i+32 +: 32];
         checks++;
         if (got !== 32'(i)) $display("FAIL b2b_slot%0d: got %h expected %h", i, got, 32'(i));
         else passed++;
      end
      @(negedge clk);
   endtask

   task automatic test_priority();
      int order [6];
      int n_gr = 0;
      logic [31:0] exp_data [7];
      logic [31:0] got;
      rd_en = 1'b1;
      exp_data = '{32'hA0, 32'hA1, 32'hA2, 32'hD0, 32'hD1, 32'hD2, 32'h0};
      for (int i = 0; i < 3; i++) push(3, 32'hD0 + 32'(i), 2'b00);
      for (int i = 0; i < 3; i++) push(0, 32'hA0 + 32'(i), 2'b01);
      for (int c = 0; c < 60; c++) begin
         #1;
         if (req != 4'b0000 && n_gr < 6) begin
            order[n_gr] = (req == 4'b0001) ? 0 : (req == 4'b0010) ? 1 : (req == 4'b0100) ? 2 : 3;
            n_gr++;
         end
         if (valid === 1'b1) break;
         @(negedge clk);
      end
      $display("frame: tag=%08h slot0=%08h grants=%0d", dout[31:0], dout[63:32], n_gr);
      checks++;
      if (n_gr != 6) $display("FAIL prio_grant_count: got %0d expected 6", n_gr);
      else passed++;
      checks++;
      if (n_gr == 6 && !(order[0] == 0 && order[2] == 0 && order[3] == 3 && order[5] == 3))
         $display("FAIL prio_order: got %0d%0d%0d%0d%0d%0d expected 000333",
                  order[0], order[1], order[2], order[3], order[4], order[5]);
      else passed++;
      checks++;
      if (dout[31:0] !== 32'hC0CC_C111) $display("FAIL prio_tag: got %h expected c0ccc111", dout[31:0]);
      else passed++;
      for (int i = 0; i < 7; i++) begin
         got = dout[32*i+32 +: 32];
         checks++;
         if (got !== exp_data[i]) $display("FAIL prio_slot%0d: got %h expected %h", i, got, exp_data[i]);
         else passed++;
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      int n_req = 0;
      rd_en = 1'b0;
      for (int k = 1; k <= 20; k++) push(1, 32'h100 + 32'(k), 2'b00);
      for (int c = 0; c < 40; c++) begin
         #1;
         if (req[1] === 1'b1) n_req++;
         @(negedge clk);
      end
      checks++;
      if (n_req != 14) $display("FAIL bp_req_stall: got %0d expected 14", n_req);
      else passed++;
      $display("frame: tag=%08h slot0=%08h held", dout[31:0], dout[63:32]);
      checks++;
      if (valid !== 1'b1 || dout[31:0] !== 32'hE444_4444 || dout[63:32] !== 32'h101 || dout[255:224] !== 32'h107)
         $display("FAIL bp_frame1: got valid %b tag %h s0 %h s6 %h expected 1 e4444444 101 107",
                  valid, dout[31:0], dout[63:32], dout[255:224]);
      else passed++;
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      $display("frame: tag=%08h slot0=%08h", dout[31:0], dout[63:32]);
      checks++;
      if (valid !== 1'b1 || dout[31:0] !== 32'hE444_4444 || dout[63:32] !== 32'h108 || dout[255:224] !== 32'h10E)
         $display("FAIL bp_frame2: got valid %b tag %h s0 %h s6 %h expected 1 e4444444 108 10e",
                  valid, dout[31:0], dout[63:32], dout[255:224]);
      else passed++;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (req[1] === 1'b1) n_req++;
         @(negedge clk);
      end
      checks++;
      if (n_req != 20) $display("FAIL bp_req_total: got %0d expected 20", n_req);
      else passed++;
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      $display("frame: tag=%08h slot0=%08h", dout[31:0], dout[63:32]);
      checks++;
      if (valid !== 1'b1 || dout[31:0] !== 32'hC044_4444 || dout[63:32] !== 32'h10F ||
          dout[223:192] !== 32'h114 || dout[255:224] !== 32'h0)
         $display("FAIL bp_frame3: got valid %b tag %h s0 %h s5 %h s6 %h expected 1 c0444444 10f 114 0",
                  valid, dout[31:0], dout[63:32], dout[223:192], dout[255:224]);
      else passed++;
      rd_en = 1'b1;
      @(negedge clk);
      checks++;
      if (valid !== 1'b0) $display("FAIL bp_drained: got valid %b expected 0", valid);
      else passed++;
   endtask

   task automatic test_reset_mid_frame();
      int n_wr = 0;
      int cyc;
      bit ok;
      rd_en = 1'b1;
      for (int i = 0; i < 3; i++) push(3, 32'h300 + 32'(i), 2'b10);
      for (int c = 0; c < 20 && n_wr < 3; c++) begin
         @(negedge clk);
         if (wr_en[3] === 1'b1) n_wr++;
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (valid !== 1'b0 || req !== 4'b0000) $display("FAIL rst_mid: got valid %b req %b expected 0 0000", valid, req);
      else passed++;
      rst = 1'b0;
      push(1, 32'h555, 2'b11);
      wait_valid(40, cyc, ok);
      checks++;
      if (!ok || dout[31:0] !== 32'h2000_0007) $display("FAIL rst_tag: got %h (ok=%0b) expected 20000007", dout[31:0], ok);
      else passed++;
      checks++;
      if (dout[63:32] !== 32'h555 || dout[255:64] !== 192'd0)
         $display("FAIL rst_slots: got s0 %h rest %h expected 555 0", dout[63:32], dout[255:64]);
      else passed++;
      @(negedge clk);
   endtask

   task automatic test_pop_handoff();
      int n_wr = 0;
      rd_en = 1'b0;
      for (int k = 1; k <= 14; k++) push(1, 32'h600 + 32'(k), 2'b10);
      for (int c = 0; c < 60 && n_wr < 14; c++) begin
         @(negedge clk);
         if (wr_en[1] === 1'b1) n_wr++;
      end
      checks++;
      if (n_wr != 14 || valid !== 1'b1 || dout[63:32] !== 32'h601)
         $display("FAIL pop_pre: got words %0d valid %b s0 %h expected 14 1 601", n_wr, valid, dout[63:32]);
      else passed++;
      rd_en = 1'b1;
      @(negedge clk);
      $display("frame: tag=%08h slot0=%08h", dout[31:0], dout[63:32]);
      checks++;
      if (valid !== 1'b1) $display("FAIL pop_gap: got valid %b expected 1", valid);
      else passed++;
      checks++;
      if (dout[31:0] !== 32'hE666_6666 || dout[63:32] !== 32'h608 || dout[255:224] !== 32'h60E)
         $display("FAIL pop_frame: got tag %h s0 %h s6 %h expected e6666666 608 60e",
                  dout[31:0], dout[63:32], dout[255:224]);
      else passed++;
      @(negedge clk);
      checks++;
      if (valid !== 1'b0) $display("FAIL pop_drain: got valid %b expected 0", valid);
      else passed++;
      rd_en = 1'b0;
   endtask

   initial begin
      rst   = 1'b1;
      rd_en = 1'b0;
      for (int n = 0; n < 4; n++) wptr[n] = 0;
      test_reset();
      test_single_flush();
      test_back_to_back();
      test_priority();
      test_backpressure();
      test_reset_mid_frame();
      test_pop_handoff();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
